// File: rtl/ks_serial_mul_pkg.sv
// Shared types and helpers for the digit-serial carry-less multiplier.
// Holds the digit-count function, FSM state encoding and a reference product.
package ks_pkg;

    // FSM state encoding (plain vector constants for legacy tools)
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Widest operand the reference product supports
    localparam int REF_W = 128;

    // Number of D-bit digits needed to cover an N-bit operand
    function automatic int ks_digits(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

    // Plain shift-and-xor carry-less product, operands zero-extended
    function automatic logic [2*REF_W-2:0] clmul_ref(
        input logic [REF_W-1:0] a,
        input logic [REF_W-1:0] b
    );
        logic [2*REF_W-2:0] a_ext;
        logic [2*REF_W-2:0] p;
        a_ext = '0;
        a_ext[REF_W-1:0] = a;
        p = '0;
        for (int i = 0; i < REF_W; i++) begin
            if (b[i]) begin
                p = p ^ (a_ext << i);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/ks_serial_mul_if.sv
// Operand/result handshake bundle for ks_serial_mul.
// master: producer of a/b and consumer of d; slave: the multiplier.
interface ks_serial_mul_if #(
    parameter int N = 75
);

    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-2:0] d;
    logic           busy;

    modport master (
        output in_valid,
        output a,
        output b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  d,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output d,
        output busy
    );

endinterface

// File: rtl/ks_serial_mul_clmul_digit.sv
// Combinational N x D carry-less multiplier producing an N+D-1 bit product.
// Ports: a_i (N), b_i (D digit), p_o (N+D-1).
module clmul_digit #(
    parameter int N = 75,
    parameter int D = 16
) (
    input  logic [N-1:0]     a_i,
    input  logic [D-1:0]     b_i,
    output logic [N+D-2:0]   p_o
);

    logic [N+D-2:0] a_ext;

    always_comb begin
        a_ext = '0;
        a_ext[N-1:0] = a_i;
        p_o = '0;
        for (int j = 0; j < D; j++) begin
            if (b_i[j]) begin
                p_o = p_o ^ (a_ext << j);
            end
        end
    end

endmodule

// File: rtl/ks_serial_mul.sv
// Digit-serial GF(2)[x] multiplier: one D-bit digit of b per cycle vs all of a.
// Ports: clk, rst (async, active-high), bus (slave: a/b in, d out, handshakes).
module ks_serial_mul
    import ks_pkg::*;
#(
    parameter int N = 75,
    parameter int D = 16
) (
    input  logic           clk,
    input  logic           rst,
    ks_serial_mul_if.slave bus
);

    localparam int K  = ks_digits(N, D);
    localparam int CW = $clog2(K) + 1;
    localparam int BW = K * D;
    localparam int PW = N + D - 1;
    localparam int DW = 2 * N - 1;

    state_t          state_q;
    state_t          state_d;
    logic [N-1:0]    a_q;
    logic [N-1:0]    a_d;
    logic [BW-1:0]   b_q;
    logic [BW-1:0]   b_d;
    logic [DW-1:0]   acc_q;
    logic [DW-1:0]   acc_d;
    logic [DW-1:0]   d_q;
    logic [DW-1:0]   d_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;

    logic [PW-1:0]   pp;
    logic [DW-1:0]   pp_ext;
    logic [DW-1:0]   pp_sh;
    logic [DW-1:0]   acc_nxt;
    logic [31:0]     shamt;
    logic            last;

    // b_q is shifted right one digit per RUN cycle, so the
    // current digit always sits in the low D bits.
    clmul_digit #(
        .N (N),
        .D (D)
    ) u_digit (
        .a_i (a_q),
        .b_i (b_q[D-1:0]),
        .p_o (pp)
    );

    // Partial product placed at digit offset cnt*D. Truncation to
    // 2N-1 bits is lossless since the true degree is <= 2N-2.
    always_comb begin
        pp_ext = '0;
        pp_ext[PW-1:0] = pp;
        shamt = 32'(cnt_q) * 32'(D);
        pp_sh = pp_ext << shamt;
        acc_nxt = acc_q ^ pp_sh;
        last = (cnt_q == CW'(K - 1));
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    a_d            = bus.a;
                    b_d            = '0;
                    b_d[N-1:0]     = bus.b;
                    acc_d          = '0;
                    cnt_d          = '0;
                    state_d        = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d = acc_nxt;
                b_d   = b_q >> D;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    d_d     = acc_nxt;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.d         = d_q;

    a_hs_excl: assert property (
        @(posedge clk) disable iff (rst)
        !(bus.in_ready && bus.out_valid)
    );

    a_cnt_range: assert property (
        @(posedge clk) disable iff (rst)
        (state_q == ST_RUN) |-> (cnt_q <= CW'(K - 1))
    );

endmodule

// File: tb/tb_ks_serial_mul.sv
// Scoreboard bench for ks_serial_mul: directed cases plus random regression.
// Expected products come from a coefficient-pair model inside the bench.
module tb_ks_serial_mul;

    localparam int NCFG = 11;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;
    int   done_cnt;
    bit   rand_go;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Product by definition: coefficient x^(i+j) toggles for every a_i*b_j
    function automatic logic [254:0] ref_mul(
        input logic [127:0] a,
        input logic [127:0] b,
        input int           n
    );
        logic [254:0] p;
        p = '0;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++)
                if (a[i] && b[j]) p[i+j] = ~p[i+j];
        return p;
    endfunction

    function automatic int cfg_n(input int g);
        case (g)
            0, 1, 2, 3: return 75;
            4, 5, 6, 7: return 64;
            default:    return 11;
        endcase
    endfunction

    function automatic int cfg_d(input int g);
        case (g)
            0: return 1;   1: return 7;  2: return 16; 3: return 75;
            4: return 1;   5: return 7;  6: return 16; 7: return 64;
            8: return 1;   9: return 7;  default: return 11;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- directed instances ----------------
    ks_serial_mul_if #(.N(75)) m75 ();
    ks_serial_mul #(.N(75), .D(16)) u75 (
        .clk (clk), .rst (rst), .bus (m75.slave)
    );
    ks_serial_mul_if #(.N(8)) m8 ();
    ks_serial_mul #(.N(8), .D(8)) u8 (
        .clk (clk), .rst (rst), .bus (m8.slave)
    );

    logic [148:0] q75[$];
    logic [14:0]  q8[$];
    logic [148:0] e75;
    logic [14:0]  e8;

    always @(negedge clk) begin
        if (m75.out_valid && m75.out_ready) begin
            if (q75.size() == 0)
                chk("spurious_valid75", 256'(m75.out_valid), 256'd0);
            else begin
                e75 = q75.pop_front();
                chk("sb_d75", 256'(m75.d), 256'(e75));
            end
        end
        if (m8.out_valid && m8.out_ready) begin
            if (q8.size() == 0)
                chk("spurious_valid8", 256'(m8.out_valid), 256'd0);
            else begin
                e8 = q8.pop_front();
                chk("sb_d8", 256'(m8.d), 256'(e8));
            end
        end
    end

    task automatic issue75(input logic [74:0] a, input logic [74:0] b,
                           input bit expect_out);
        int t;
        logic [254:0] full;
        t = 0;
        while (!m75.in_ready && t < 500) begin
            @(posedge clk); #1; t++;
        end
        chk("in_ready75_wait", 256'(m75.in_ready), 256'd1);
        m75.a = a;
        m75.b = b;
        m75.in_valid = 1'b1;
        if (expect_out) begin
            full = ref_mul(128'(a), 128'(b), 75);
            q75.push_back(full[148:0]);
        end
        @(posedge clk); #1;
        m75.in_valid = 1'b0;
    endtask

    task automatic wait_out75(output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!m75.out_valid && lat < 200);
    endtask

    // ---------------- random regression instances ----------------
    for (genvar g = 0; g < NCFG; g++) begin : gen_cfg
        localparam int GN = cfg_n(g);
        localparam int GD = cfg_d(g);
        localparam int GK = (GN + GD - 1) / GD;

        ks_serial_mul_if #(.N(GN)) bus ();
        ks_serial_mul #(.N(GN), .D(GD)) dut (
            .clk (clk), .rst (rst), .bus (bus.slave)
        );

        logic [2*GN-2:0] q[$];
        logic [2*GN-2:0] em;

        initial begin : drv
            int issued;
            int cyc;
            int nops;
            logic [GN-1:0] ra;
            logic [GN-1:0] rb;
            logic [254:0] full;
            bus.in_valid = 1'b0;
            bus.a = '0;
            bus.b = '0;
            wait (rand_go);
            @(posedge clk); #1;
            nops = 20000 / (GK + 6);
            issued = 0;
            cyc = 0;
            while (issued < nops && cyc < 60000) begin
                for (int i = 0; i < GN; i++) begin
                    ra[i] = 1'($urandom);
                    rb[i] = 1'($urandom);
                end
                bus.a = ra;
                bus.b = rb;
                if (bus.in_ready && $urandom_range(0, 3) != 0) begin
                    bus.in_valid = 1'b1;
                    full = ref_mul(128'(ra), 128'(rb), GN);
                    q.push_back(full[2*GN-2:0]);
                    issued++;
                end else begin
                    // junk offered while busy must be ignored
                    bus.in_valid = !bus.in_ready && ($urandom_range(0, 1) == 1);
                end
                @(posedge clk); #1;
                cyc++;
            end
            bus.in_valid = 1'b0;
            chk($sformatf("rand_issue_N%0d_D%0d", GN, GD),
                256'(issued), 256'(nops));
            cyc = 0;
            while (q.size() != 0 && cyc < 3000) begin
                @(posedge clk); #1; cyc++;
            end
            chk($sformatf("rand_drain_N%0d_D%0d", GN, GD),
                256'(q.size()), 256'd0);
            done_cnt++;
        end

        initial begin : rdy
            bus.out_ready = 1'b0;
            forever begin
                @(posedge clk); #1;
                bus.out_ready = ($urandom_range(0, 2) != 0);
            end
        end

        always @(negedge clk) begin
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0)
                    chk("rand_spurious", 256'(bus.out_valid), 256'd0);
                else begin
                    em = q.pop_front();
                    chk($sformatf("rand_d_N%0d_D%0d", GN, GD),
                        256'(bus.d), 256'(em));
                end
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin : main
        int lat;
        int t;
        logic [74:0]  ta;
        logic [74:0]  tb;
        logic [148:0] ed;
        logic [254:0] full;

        n_chk = 0;
        n_fail = 0;
        done_cnt = 0;
        rand_go = 1'b0;
        m75.in_valid = 1'b0; m75.a = '0; m75.b = '0; m75.out_ready = 1'b0;
        m8.in_valid = 1'b0;  m8.a = '0;  m8.b = '0;  m8.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_in_ready", 256'(m75.in_ready), 256'd1);
        chk("rst_out_valid", 256'(m75.out_valid), 256'd0);
        chk("rst_busy", 256'(m75.busy), 256'd0);
        chk("rst_d", 256'(m75.d), 256'd0);
        chk("rst_d8", 256'(m8.d), 256'd0);

        // 3 * 3 = x^2 + 1
        m75.out_ready = 1'b1;
        issue75(75'h3, 75'h3, 1'b1);
        chk("busy_run", 256'(m75.busy), 256'd1);
        chk("in_ready_run", 256'(m75.in_ready), 256'd0);
        wait_out75(lat);
        chk("latency_k5", 256'(lat), 256'd5);
        chk("d_3x3", 256'(m75.d), 256'h5);
        @(posedge clk); #1;
        chk("in_ready_after_drain", 256'(m75.in_ready), 256'd1);
        chk("out_valid_after_drain", 256'(m75.out_valid), 256'd0);
        chk("d_hold_idle", 256'(m75.d), 256'h5);

        // top coefficients: x^74 * x^74 = x^148
        ta = '0; ta[74] = 1'b1;
        ed = '0; ed[148] = 1'b1;
        issue75(ta, ta, 1'b1);
        wait_out75(lat);
        chk("d_top_bit", 256'(m75.d), 256'(ed));
        @(posedge clk); #1;

        // all-ones * 1 exercises the partial final digit
        ta = '1;
        issue75(ta, 75'h1, 1'b1);
        wait_out75(lat);
        chk("d_ones_x1", 256'(m75.d), 256'(ta));
        @(posedge clk); #1;

        // backpressure with an ignored in_valid pulse
        m75.out_ready = 1'b0;
        ta = 75'h12345_6789_ABCD_EF01;
        tb = 75'h3_00F0_0FF0_F00F;
        full = ref_mul(128'(ta), 128'(tb), 75);
        ed = full[148:0];
        issue75(ta, tb, 1'b1);
        wait_out75(lat);
        chk("latency_bp", 256'(lat), 256'd5);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", 256'(m75.out_valid), 256'd1);
            chk("bp_d", 256'(m75.d), 256'(ed));
            if (i == 3) begin
                m75.a = 75'h5; m75.b = 75'h7; m75.in_valid = 1'b1;
            end
            if (i == 4) m75.in_valid = 1'b0;
            @(posedge clk); #1;
        end
        m75.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_in_ready_after", 256'(m75.in_ready), 256'd1);
        chk("bp_d_hold", 256'(m75.d), 256'(ed));

        // reset on the third RUN cycle abandons the pair
        issue75(75'h1F, 75'h2B, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("arst_busy", 256'(m75.busy), 256'd0);
        chk("arst_in_ready", 256'(m75.in_ready), 256'd1);
        chk("arst_out_valid", 256'(m75.out_valid), 256'd0);
        chk("arst_d", 256'(m75.d), 256'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("abort_no_valid", 256'(m75.out_valid), 256'd0);
        end
        issue75(75'h6, 75'h3, 1'b1);
        wait_out75(lat);
        chk("latency_after_rst", 256'(lat), 256'd5);
        chk("d_6x3", 256'(m75.d), 256'hA);
        @(posedge clk); #1;

        // K = 1 configuration
        m8.out_ready = 1'b1;
        m8.a = 8'hFF; m8.b = 8'hFF; m8.in_valid = 1'b1;
        full = ref_mul(128'(8'hFF), 128'(8'hFF), 8);
        q8.push_back(full[14:0]);
        @(posedge clk); #1;
        m8.in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!m8.out_valid && lat < 50);
        chk("latency_k1", 256'(lat), 256'd1);
        chk("d_ff_ff", 256'(m8.d), 256'h5555);
        @(posedge clk); #1;
        chk("k1_in_ready", 256'(m8.in_ready), 256'd1);

        // random regression across configurations
        rand_go = 1'b1;
        t = 0;
        while (done_cnt < NCFG && t < 80000) begin
            @(posedge clk); t++;
        end
        chk("rand_all_done", 256'(done_cnt), 256'(NCFG));
        chk("dir_queue75_empty", 256'(q75.size()), 256'd0);
        chk("dir_queue8_empty", 256'(q8.size()), 256'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
